// File: rtl/edabk_receiver.sv
// Oversampling UART-style receiver: 2-flop synchronizer, start-bit validation at mid-bit,
// LSB-first data capture at bit centres, stop-bit check with break handling.
`ifndef CFG_CLK_DIV
`define CFG_CLK_DIV 16
`endif
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module edabk_receiver #(
  parameter int CLK_DIV    = `CFG_CLK_DIV,
  parameter int DATA_WIDTH = `CFG_DATA_WIDTH
) (
  input  logic                  bclk,
  input  logic                  reset_n,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_out,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int SW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [SW-1:0] HalfM1  = SW'(CLK_DIV / 2 - 1);
  localparam logic [SW-1:0] FullM1  = SW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LastBit = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_sync1;
  logic                  r_rx_s;
  logic [SW-1:0]         r_sample_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_rx_out;
  logic                  r_valid;
  logic                  r_frame_err;
  logic                  w_half_hit;
  logic                  w_full_hit;
  logic                  w_shift_en;
  logic                  w_load_word;
  logic                  w_frame_bad;

  assign w_half_hit = (r_sample_cnt == HalfM1);
  assign w_full_hit = (r_sample_cnt == FullM1);

  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_load_word  = 1'b0;
    w_frame_bad  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!r_rx_s) w_state_next = StStart;
      end
      StStart: begin
        // A start bit that is gone by mid-bit is treated as line noise.
        if (w_half_hit) w_state_next = r_rx_s ? StIdle : StData;
      end
      StData: begin
        if (w_full_hit) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == LastBit) w_state_next = StStop;
        end
      end
      StStop: begin
        if (w_full_hit) begin
          w_load_word  = r_rx_s;
          w_frame_bad  = ~r_rx_s;
          w_state_next = r_rx_s ? StIdle : StBreak;
        end
      end
      StBreak: begin
        if (r_rx_s) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1      <= 1'b1;
      r_rx_s       <= 1'b1;
      r_state      <= StIdle;
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_rx_out     <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync1     <= rx_in;
      r_rx_s      <= r_sync1;
      r_state     <= w_state_next;
      r_valid     <= w_load_word;
      r_frame_err <= w_frame_bad;
      if (w_state_next != r_state) begin
        r_sample_cnt <= '0;
        r_bit_cnt    <= '0;
      end else begin
        r_sample_cnt <= w_full_hit ? '0 : r_sample_cnt + SW'(1);
        if (w_shift_en) r_bit_cnt <= r_bit_cnt + BW'(1);
      end
      // Shift also on the DATA->STOP transition so the last bit is captured.
      if (w_shift_en) r_shift <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
      if (w_load_word) r_rx_out <= r_shift;
    end
  end

  assign rx_out    = r_rx_out;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_edabk_receiver.sv
// Directed bench for edabk_receiver (CLK_DIV=16, DATA_WIDTH=8) with a serial frame driver.
module tb_edabk_receiver;

  localparam int CLK_DIV = 16;

  logic       bclk = 1'b0;
  logic       reset_n;
  logic       rx_in;
  logic [7:0] rx_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_both = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;
  logic [7:0] words[$];

  edabk_receiver #(.CLK_DIV(16), .DATA_WIDTH(8)) dut (
    .bclk      (bclk),
    .reset_n   (reset_n),
    .rx_in     (rx_in),
    .rx_out    (rx_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 bclk = ~bclk;

  always @(posedge bclk) cyc++;

  always @(negedge bclk) begin
    if (valid) begin
      n_valid++;
      words.push_back(rx_out);
      last_valid_cyc = cyc;
    end
    if (frame_err) n_ferr++;
    if (valid && frame_err) n_both++;
  end

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge bclk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CLK_DIV) @(posedge bclk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    rx_in   = 1'b1;
    repeat (3) @(posedge bclk);
    #1;
    n_total++;
    if (rx_out !== 8'h00) $display("FAIL reset_rx_out: got %h expected 00", rx_out);
    else n_pass++;
    n_total++;
    if ({valid, frame_err, busy} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {valid, frame_err, busy});
    else n_pass++;
    reset_n = 1'b1;
    idle(5);
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_frame_a5;
    int v0, f0, lat;
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'hA5, 1'b1);
    idle(20);
    lat = last_valid_cyc - start_cyc - 1;
    n_total++;
    if (n_valid - v0 !== 1) $display("FAIL a5_valid_count: got %0d expected 1", n_valid - v0);
    else n_pass++;
    n_total++;
    if (rx_out !== 8'hA5) $display("FAIL a5_rx_out: got %h expected a5", rx_out);
    else n_pass++;
    n_total++;
    if (n_ferr - f0 !== 0) $display("FAIL a5_frame_err: got %0d expected 0", n_ferr - f0);
    else n_pass++;
    n_total++;
    if (lat < 153 || lat > 155) $display("FAIL a5_latency: got %0d expected 154+/-1", lat);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL a5_busy_after: got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    rx_in = 1'b0;
    repeat (4) @(posedge bclk);
    #1;
    rx_in = 1'b1;
    n_total++;
    if (busy !== 1'b1) $display("FAIL glitch_enters_start: got %b expected 1", busy);
    else n_pass++;
    idle(30);
    n_total++;
    if (busy !== 1'b0) $display("FAIL glitch_back_idle: got %b expected 0", busy);
    else n_pass++;
    n_total++;
    if ((n_valid - v0) + (n_ferr - f0) !== 0)
      $display("FAIL glitch_pulses: got %0d expected 0", (n_valid - v0) + (n_ferr - f0));
    else n_pass++;
    n_total++;
    if (rx_out !== 8'hA5) $display("FAIL glitch_rx_out: got %h expected a5", rx_out);
    else n_pass++;
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(posedge bclk);
    #1;
    n_total++;
    if (busy !== 1'b1) $display("FAIL ferr_break_busy: got %b expected 1", busy);
    else n_pass++;
    n_total++;
    if (n_ferr - f0 !== 1) $display("FAIL ferr_count: got %0d expected 1", n_ferr - f0);
    else n_pass++;
    n_total++;
    if (n_valid - v0 !== 0) $display("FAIL ferr_no_valid: got %0d expected 0", n_valid - v0);
    else n_pass++;
    n_total++;
    if (rx_out !== 8'hA5) $display("FAIL ferr_rx_out: got %h expected a5", rx_out);
    else n_pass++;
    idle(6);
    n_total++;
    if (busy !== 1'b0) $display("FAIL ferr_release_idle: got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int v0;
    logic [7:0] exp_w[3];
    exp_w[0] = 8'h00;
    exp_w[1] = 8'hFF;
    exp_w[2] = 8'h55;
    v0 = n_valid;
    for (int i = 0; i < 3; i++) send_frame(exp_w[i], 1'b1);
    idle(20);
    n_total++;
    if (n_valid - v0 !== 3) $display("FAIL b2b_count: got %0d expected 3", n_valid - v0);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (v0 + i < words.size()) begin
        n_total++;
        if (words[v0+i] !== exp_w[i])
          $display("FAIL b2b_word%0d: got %h expected %h", i, words[v0+i], exp_w[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_abort;
    int v0, f0;
    logic [7:0] d;
    d  = 8'h81;
    v0 = n_valid;
    f0 = n_ferr;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx_in = d[4];
    repeat (8) @(posedge bclk);
    #1;
    n_total++;
    if (busy !== 1'b1) $display("FAIL abort_midframe_busy: got %b expected 1", busy);
    else n_pass++;
    reset_n = 1'b0;
    rx_in   = 1'b1;
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL abort_async_busy: got %b expected 0", busy);
    else n_pass++;
    n_total++;
    if (rx_out !== 8'h00) $display("FAIL abort_async_rx_out: got %h expected 00", rx_out);
    else n_pass++;
    repeat (3) @(posedge bclk);
    #1;
    reset_n = 1'b1;
    idle(10);
    send_frame(8'h7E, 1'b1);
    idle(20);
    n_total++;
    if (n_valid - v0 !== 1) $display("FAIL abort_valid_count: got %0d expected 1", n_valid - v0);
    else n_pass++;
    n_total++;
    if (rx_out !== 8'h7E) $display("FAIL abort_rx_out: got %h expected 7e", rx_out);
    else n_pass++;
    n_total++;
    if (n_ferr - f0 !== 0) $display("FAIL abort_frame_err: got %0d expected 0", n_ferr - f0);
    else n_pass++;
  endtask

  task automatic test_loopback;
    int v0, f0, gap;
    logic [7:0] sent[$];
    logic [7:0] w;
    v0 = n_valid;
    f0 = n_ferr;
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom_range(0, 255));
      sent.push_back(w);
      send_frame(w, 1'b1);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    idle(40);
    n_total++;
    if (n_valid - v0 !== 256) $display("FAIL loop_count: got %0d expected 256", n_valid - v0);
    else n_pass++;
    n_total++;
    if (n_ferr - f0 !== 0) $display("FAIL loop_frame_err: got %0d expected 0", n_ferr - f0);
    else n_pass++;
    for (int i = 0; i < 256; i++) begin
      if (v0 + i < words.size()) begin
        n_total++;
        if (words[v0+i] !== sent[i])
          $display("FAIL loop_word%0d: got %h expected %h", i, words[v0+i], sent[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_frame_a5;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_abort;
    test_loopback;
    n_total++;
    if (n_both !== 0) $display("FAIL valid_and_ferr_overlap: got %0d expected 0", n_both);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/edabk_receiver.md
EDABK_RECEIVER -- requirements
Module: edabk_receiver

Interface
REQ-001 Parameter CLK_DIV, default `CFG_CLK_DIV, bclk cycles per serial bit (oversampling factor), even, >= 4.
REQ-002 Parameter DATA_WIDTH, default `CFG_DATA_WIDTH, data bits per frame.
REQ-003 bclk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous reset, active low.
REQ-005 rx_in  input  1  serial line, idle high, asynchronous to bclk.
REQ-006 rx_out  output  DATA_WIDTH  last correctly framed received word.
REQ-007 valid  output  1  one-cycle pulse: rx_out updated with a new word.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 busy  output  1  high whenever FSM is not in IDLE.

Function
REQ-010 Frame format SHALL match edabk_transmitter: 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1), no parity.
REQ-011 rx_in SHALL pass through a 2-flop synchronizer (both flops reset to 1); only the synchronized value rx_s is used.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-013 Sample counter SHALL be $clog2(CLK_DIV) bits; bit counter SHALL be $clog2(DATA_WIDTH+1) bits; both cleared on every state entry.
REQ-014 IDLE: rx_s == 0 -> START.
REQ-015 START: at sample count CLK_DIV/2-1, rx_s == 0 -> DATA; rx_s == 1 -> IDLE (glitch rejected, no pulse output).
REQ-016 DATA: at each sample count CLK_DIV-1 (bit centre), rx_s SHALL shift into shift register MSB, register shifts right, counter wraps to 0, bit counter increments.
REQ-017 DATA: after DATA_WIDTH-th sample -> STOP.
REQ-018 STOP: at sample count CLK_DIV-1, rx_s == 1 -> rx_out <= shift register, valid = 1 for one cycle, -> IDLE.
REQ-019 STOP: at sample count CLK_DIV-1, rx_s == 0 -> frame_err = 1 for one cycle, rx_out unchanged, -> BREAK.
REQ-020 BREAK: remain until rx_s == 1, then -> IDLE; no new frame starts while line held low.
REQ-021 valid and frame_err SHALL never assert in the same cycle.
REQ-022 Nominal latency: valid rises 2 + CLK_DIV/2 + (DATA_WIDTH+1)*CLK_DIV bclk cycles after first low rx_in sample (tolerance +/-1).
REQ-023 Back-to-back frames (stop bit immediately followed by start bit) SHALL be received without loss.
REQ-024 rx_out SHALL hold its value between valid pulses.
REQ-025 busy SHALL be combinational from state (state != IDLE).

Reset
REQ-026 reset_n low SHALL immediately force: state IDLE, counters 0, shift register 0, rx_out 0, valid 0, frame_err 0, busy 0, sync flops 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no valid/frame_err pulse; after release the block waits for a new start bit.

Verification (CLK_DIV=16, DATA_WIDTH=8)
REQ-028 Frame 0xA5, ideal timing -> exactly one valid pulse, rx_out=0xA5, frame_err=0, valid at cycle 154+/-1 from start edge.
REQ-029 Low glitch of 4 bclk on idle line -> returns to IDLE, no valid, no frame_err, rx_out unchanged.
REQ-030 Frame 0x3C with stop bit forced 0, line held low 40 cycles then high -> one frame_err pulse, no valid, rx_out unchanged, busy high until line high, then IDLE.
REQ-031 Back-to-back 0x00, 0xFF, 0x55 -> three valid pulses, rx_out 0x00, 0xFF, 0x55 in order.
REQ-032 reset_n low during data bit 4 of 0x81, then clean 0x7E -> no pulse for aborted frame, single valid with rx_out=0x7E.
REQ-033 Loopback edabk_transmitter.tx_out -> rx_in, 256 random words -> every received word equals transmitted tx_in, zero frame_err.
